// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver sampling the line on an oversampling tick; one byte register with ready/overrun flags.
// rx_status follows the tick that samples mid stop bit; no backpressure, unread bytes are overwritten and flagged.
module uart_rx_oversample #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       uart_rx,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_status,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_ready_q, rx_ready_d;
  logic             rx_status_q, rx_status_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             sync_q, rx_s_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      sync_q <= uart_rx;
      rx_s_q <= sync_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      rx_status_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_ready_q  <= rx_ready_d;
      rx_status_q <= rx_status_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_ready_d  = rx_ready_q;
    rx_status_d = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;

    // A good-byte write below overrides this clear when both land in the same clk.
    if (rx_read) rx_ready_d = 1'b0;

    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end
        START: begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (tick_cnt_q == FULL_LAST) begin
            shreg_d    = {rx_s_q, shreg_q[7:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (tick_cnt_q == FULL_LAST) begin
            // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
            state_d    = IDLE;
            tick_cnt_d = '0;
            if (rx_s_q) begin
              rx_data_d   = shreg_q;
              rx_status_d = 1'b1;
              rx_ready_d  = 1'b1;
              if (rx_ready_q && !rx_read) overrun_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_ready  = rx_ready_q;
  assign rx_status = rx_status_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: randomized and directed 8N1 frames, a cycle-accurate expected-event
// queue derived from frame timing, and a per-clk monitor with a byte-register/flag model.
module tb_uart_rx_oversample;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_tick = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_read = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready, rx_status, frame_err, overrun;

  uart_rx_oversample #(.OVERSAMPLE(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .uart_rx(uart_rx), .rx_read(rx_read),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_status(rx_status), .frame_err(frame_err),
    .overrun(overrun)
  );

  typedef struct {
    int         w;
    bit         good;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic rd_at_edge = 1'b0;
  bit   rand_done;

  logic       ready_m = 1'b0;
  logic       ovr_m = 1'b0;
  logic [7:0] data_m = 8'h00;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rd_at_edge <= rx_read;
  end

  // Tick lands on every posedge whose index is a multiple of 4.
  always @(negedge clk) baud_tick = ((cyc + 1) % 4 == 0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Line driven low at the negedge following posedge k is seen by the FSM at posedge k+3; it reacts
  // on the first tick from there and samples mid stop 9.5 bits (152 ticks = 608 clk) later.
  function automatic int calc_w(input int k);
    int p;
    p = ((k + 3 + 3) / 4) * 4;
    return p + 608;
  endfunction

  // Caller is at a negedge; returns at the negedge ending the stop bit (line still at stop level).
  task automatic send_frame(input logic [7:0] d, input bit stop, input int abort_bits);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    if (abort_bits == 0) exp_q.push_back('{calc_w(cyc), stop, d});
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      if (abort_bits != 0 && i == abort_bits) begin
        repeat (32) @(negedge clk);
        return;
      end
      repeat (64) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_read();
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   exp_good, exp_fe;
    if (reset) begin
      ready_m = 1'b0;
      ovr_m   = 1'b0;
      data_m  = 8'h00;
      exp_q.delete();
    end else begin
      exp_good = 1'b0;
      exp_fe   = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].w == cyc) begin
        e = exp_q.pop_front();
        if (e.good) exp_good = 1'b1;
        else        exp_fe   = 1'b1;
      end
      if (exp_good) begin
        if (ready_m && !rd_at_edge) ovr_m = 1'b1;
        ready_m = 1'b1;
        data_m  = e.d;
      end else if (rd_at_edge) begin
        ready_m = 1'b0;
      end
      chk("rx_status", 32'(rx_status), 32'(exp_good));
      chk("frame_err", 32'(frame_err), 32'(exp_fe));
      chk("rx_ready", 32'(rx_ready), 32'(ready_m));
      chk("overrun", 32'(overrun), 32'(ovr_m));
      chk("rx_data", 32'(rx_data), 32'(data_m));
    end
  end

  initial begin
    int k1;
    int w2;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("reset_rx_data", 32'(rx_data), 0);
    chk("reset_rx_ready", 32'(rx_ready), 0);
    chk("reset_overrun", 32'(overrun), 0);
    @(negedge clk);
    idle(100);

    send_frame(8'hA5, 1'b1, 0);
    idle(128);
    pulse_read();
    idle(64);

    uart_rx = 1'b0;
    repeat (12) @(negedge clk);
    idle(128);
    send_frame(8'h3C, 1'b1, 0);
    idle(64);
    pulse_read();
    idle(64);

    send_frame(8'h5A, 1'b0, 0);
    idle(192);

    // Second byte written in the same clk as rx_read: write must win, no overrun.
    k1 = cyc;
    w2 = calc_w(k1 + 640);
    fork
      begin
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
      end
      begin
        while (cyc != w2 - 1) @(negedge clk);
        pulse_read();
      end
    join
    idle(128);
    chk("t6_ready", 32'(rx_ready), 1);
    chk("t6_overrun", 32'(overrun), 0);
    pulse_read();
    idle(64);

    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    idle(128);
    chk("t4_overrun", 32'(overrun), 1);
    chk("t4_data", 32'(rx_data), 32'hFF);

    send_frame(8'hC3, 1'b1, 5);
    #2 reset = 1'b1;
    #1;
    chk("arst_rx_data", 32'(rx_data), 0);
    chk("arst_rx_ready", 32'(rx_ready), 0);
    chk("arst_overrun", 32'(overrun), 0);
    uart_rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    idle(128);
    send_frame(8'h81, 1'b1, 0);
    idle(128);
    chk("t5_data", 32'(rx_data), 32'h81);

    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 20; n++) begin
          logic [7:0] d;
          bit         stop;
          int         gap;
          d    = 8'($urandom);
          stop = ($urandom_range(0, 5) != 0);
          send_frame(d, stop, 0);
          gap = stop ? $urandom_range(0, 2) : 2;
          if (gap != 0) idle(gap * 64);
        end
        idle(128);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          rx_read = ($urandom_range(0, 149) == 0);
        end
        rx_read = 1'b0;
      end
    join

    idle(200);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
